// File: rtl/vga_pkg.sv
// Shared VGA constants, the pixel timing bundle and the bound test used by the rectangle renderer.
// Pure definitions: no logic, no latency and no flow control.
package vga_pkg;

  localparam int unsigned RECT_WIDTH      = 64;
  localparam int unsigned RECT_HEIGHT     = 64;
  localparam logic [11:0] RECT_COLOR      = 12'hF80;
  localparam logic [11:0] TRANSPARENT_KEY = 12'hF0F;
  localparam int unsigned HOR_PIXELS      = 1024;
  localparam int unsigned VER_PIXELS      = 768;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } vga_timing_t;

  // 13-bit span test so that base+size can never wrap back onto the left/top of the screen.
  function automatic logic in_span(input logic [10:0] cnt, input logic [11:0] base,
                                   input logic [12:0] size);
    logic [12:0] lo;
    logic [12:0] hi;
    logic [12:0] c;
    lo = {1'b0, base};
    hi = lo + size;
    c  = {2'b00, cnt};
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/rect_rom.sv
// 64x64 12-bit rectangle image, contents built at elaboration; used only when RECT_IMAGE_EN is defined.
// One cycle read latency (registered output); accepts an address every cycle, no backpressure.
module rect_rom (
  input  logic        clk,
  input  logic [11:0] addr_i,
  output logic [11:0] data_o
);

  logic [11:0] mem [4096];
  logic [11:0] data_q;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = {i[3:0], i[9:6], i[5:2] ^ i[11:8]};
    end
    mem[0] = vga_pkg::TRANSPARENT_KEY;
    mem[1] = 12'h123;
  end

  always_ff @(posedge clk) begin
    data_q <= mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/draw_rect_render.sv
// Overlays a frame-latched rectangle (solid, or ROM image with RECT_IMAGE_EN) on a VGA stream.
// Fixed 2-cycle latency on every output; one pixel per cycle, no backpressure.
module draw_rect_render #(
  parameter int unsigned RECT_WIDTH  = vga_pkg::RECT_WIDTH,
  parameter int unsigned RECT_HEIGHT = vga_pkg::RECT_HEIGHT,
  parameter logic [11:0] RECT_COLOR  = vga_pkg::RECT_COLOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  import vga_pkg::*;

  localparam logic [12:0] W13 = 13'(RECT_WIDTH);
  localparam logic [12:0] H13 = 13'(RECT_HEIGHT);

  vga_timing_t tim_in;
  vga_timing_t tim1_q;
  vga_timing_t tim2_q;

  logic        vblnk_prev_q;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        inside_q, inside_d;
  logic [11:0] rgb1_q;
  logic [11:0] rgb_q, rgb_d;
  logic        fill_vld;
  logic [11:0] fill_dat;

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in};

  // Position is sampled only on the vblank rising edge so a frame is never torn.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vblnk_in && !vblnk_prev_q) begin
      x_d = xpos;
      y_d = ypos;
    end
  end

  always_comb begin
    inside_d = in_span(hcount_in, x_q, W13) && in_span(vcount_in, y_q, H13) &&
               !hblnk_in && !vblnk_in;
  end

`ifdef RECT_IMAGE_EN
  logic [11:0] rom_addr_d;
  logic [11:0] rom_dat;

  // Only the low six bits of each offset matter, so subtract on those directly.
  assign rom_addr_d = {vcount_in[5:0] - y_q[5:0], hcount_in[5:0] - x_q[5:0]};

  rect_rom u_rect_rom (
    .clk    (clk),
    .addr_i (rom_addr_d),
    .data_o (rom_dat)
  );

  assign fill_vld = inside_q && (rom_dat != TRANSPARENT_KEY);
  assign fill_dat = rom_dat;
`else
  assign fill_vld = inside_q;
  assign fill_dat = RECT_COLOR;
`endif

  always_comb begin
    rgb_d = fill_vld ? fill_dat : rgb1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      tim1_q       <= '0;
      inside_q     <= 1'b0;
      rgb1_q       <= '0;
      tim2_q       <= '0;
      rgb_q        <= '0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      x_q          <= x_d;
      y_q          <= y_d;
      tim1_q       <= tim_in;
      inside_q     <= inside_d;
      rgb1_q       <= rgb_in;
      tim2_q       <= tim1_q;
      rgb_q        <= rgb_d;
    end
  end

  assign hcount_out = tim2_q.hcount;
  assign vcount_out = tim2_q.vcount;
  assign hsync_out  = tim2_q.hsync;
  assign hblnk_out  = tim2_q.hblnk;
  assign vsync_out  = tim2_q.vsync;
  assign vblnk_out  = tim2_q.vblnk;
  assign rgb_out    = rgb_q;

endmodule
